// File: rtl/rpn_input_conditioner.sv
// Button/switch front end for the RPN CPU: sync, debounce, sticky release flags, DINP source.
// Optional RPN_DINP_CAPTURE_EN: dinp snapshots the switches on the SMPL_BIT release instead of tracking them.
module rpn_input_conditioner #(
    parameter int          N_BTN     = 8,
    parameter logic [15:0] DB_CYCLES = 16'd50000,
    parameter int          SMPL_BIT  = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [7:0]       sw_raw,
    input  logic [N_BTN-1:0] atc_clr,
    output logic [N_BTN-1:0] atc_flag,
    output logic [N_BTN-1:0] btn_level,
    output logic [7:0]       dinp
);

    localparam int             CW       = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 16'd1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } db_state_t;

    logic [N_BTN-1:0] r_btn_s1, r_btn_s2;
    logic [7:0]       r_sw_s1, r_sw_s2;
    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] r_level_d;
    logic [N_BTN-1:0] w_rel;
    logic [N_BTN-1:0] r_flag;
    logic [7:0]       r_dinp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_btn_s1 <= btn_raw;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= sw_raw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_db
        db_state_t     r_state, w_state_nxt;
        logic [CW-1:0] r_cnt, w_cnt_nxt;
        logic          r_lvl, w_lvl_nxt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
                r_lvl   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_lvl   <= w_lvl_nxt;
            end
        end

        // Toggle on the DB_CYCLES-th consecutive differing sample; counter stops at CNT_LAST.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_lvl_nxt   = r_lvl;
            unique case (r_state)
                ST_STABLE: begin
                    if (r_btn_s2[gi] != r_lvl) begin
                        w_state_nxt = ST_COUNT;
                        w_cnt_nxt   = CW'(1);
                    end
                end
                ST_COUNT: begin
                    if (r_btn_s2[gi] == r_lvl) begin
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_lvl_nxt   = ~r_lvl;
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
            endcase
        end

        assign w_level[gi] = r_lvl;
    end

    assign w_rel = r_level_d & ~w_level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level_d <= '0;
            r_flag    <= '0;
        end else begin
            r_level_d <= w_level;
            r_flag    <= (r_flag & ~atc_clr) | w_rel;
        end
    end

`ifdef RPN_DINP_CAPTURE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dinp <= '0;
        end else if (w_rel[SMPL_BIT]) begin
            r_dinp <= r_sw_s2;
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dinp <= '0;
        end else begin
            r_dinp <= r_sw_s2;
        end
    end
`endif

    assign atc_flag  = r_flag;
    assign btn_level = w_level;
    assign dinp      = r_dinp;

endmodule

// File: tb/tb_rpn_input_conditioner.sv
// Directed and randomized bench for rpn_input_conditioner with a short debounce window.
module tb_rpn_input_conditioner;

    localparam int NB    = 8;
    localparam int TB_DB = 4;
    localparam int SMPL  = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] btn_raw, sw_raw, atc_clr;
    logic [7:0] atc_flag, btn_level, dinp;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rpn_input_conditioner #(
        .N_BTN     (NB),
        .DB_CYCLES (16'(TB_DB)),
        .SMPL_BIT  (SMPL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .sw_raw    (sw_raw),
        .atc_clr   (atc_clr),
        .atc_flag  (atc_flag),
        .btn_level (btn_level),
        .dinp      (dinp)
    );

    // Reference: a level flips once the last TB_DB synchronised samples all disagree with it.
    logic [7:0] m_p1, m_p2, m_sw1, m_sw2;
    logic [7:0] m_lvl, m_lvl_d, m_flag, m_dinp;
    logic [7:0] m_hist [TB_DB-1];
    logic [7:0] m_diff, m_lvl_nxt, m_rel;

    always_comb begin
        m_diff = m_p2 ^ m_lvl;
        for (int j = 0; j < TB_DB-1; j++) m_diff = m_diff & (m_hist[j] ^ m_lvl);
        m_lvl_nxt = m_lvl ^ m_diff;
    end

    assign m_rel = m_lvl_d & ~m_lvl;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_p1    <= '0;
            m_p2    <= '0;
            m_sw1   <= '0;
            m_sw2   <= '0;
            m_lvl   <= '0;
            m_lvl_d <= '0;
            m_flag  <= '0;
            m_dinp  <= '0;
            for (int j = 0; j < TB_DB-1; j++) m_hist[j] <= '0;
        end else begin
            m_p1      <= btn_raw;
            m_p2      <= m_p1;
            m_sw1     <= sw_raw;
            m_sw2     <= m_sw1;
            m_hist[0] <= m_p2;
            for (int j = 1; j < TB_DB-1; j++) m_hist[j] <= m_hist[j-1];
            m_lvl     <= m_lvl_nxt;
            m_lvl_d   <= m_lvl;
            m_flag    <= (m_flag & ~atc_clr) | m_rel;
`ifdef RPN_DINP_CAPTURE_EN
            if (m_rel[SMPL]) m_dinp <= m_sw2;
`else
            m_dinp <= m_sw2;
`endif
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("flag_vs_model", atc_flag, m_flag);
            chk("level_vs_model", btn_level, m_lvl);
            chk("dinp_vs_model", dinp, m_dinp);
        end
    endtask

    int hold [NB];

    initial begin
        reset   = 1'b0;
        btn_raw = '0;
        sw_raw  = '0;
        atc_clr = '0;
        step(3);
        chk("rst_flag", atc_flag, 8'h00);
        chk("rst_level", btn_level, 8'h00);
        chk("rst_dinp", dinp, 8'h00);
        reset = 1'b1;
        step(2);

        // Press/release on channel 2
        btn_raw[2] = 1'b1;
        step(5);
        chk("press_lvl_early", btn_level, 8'h00);
        step(1);
        chk("press_lvl", btn_level, 8'h04);
        chk("press_noflag", atc_flag, 8'h00);
        step(4);
        btn_raw[2] = 1'b0;
        step(6);
        chk("rel_lvl", btn_level, 8'h00);
        chk("rel_flag_early", atc_flag, 8'h00);
        step(1);
        chk("rel_flag", atc_flag, 8'h04);
        atc_clr = 8'h04;
        step(1);
        atc_clr = '0;
        chk("clr_flag2", atc_flag, 8'h00);

        // Bounce on channel 1
        for (int k = 0; k < 10; k++) begin
            btn_raw[1] = ~btn_raw[1];
            step(2);
            chk("bounce_lvl_run", btn_level, 8'h00);
        end
        step(8);
        chk("bounce_lvl", btn_level, 8'h00);
        chk("bounce_flag", atc_flag, 8'h00);

        // Consume, then release coincident with consume
        btn_raw[0] = 1'b1;
        step(8);
        btn_raw[0] = 1'b0;
        step(7);
        chk("flag0", atc_flag, 8'h01);
        atc_clr = 8'h01;
        step(1);
        atc_clr = '0;
        chk("clr0", atc_flag, 8'h00);
        btn_raw[0] = 1'b1;
        step(8);
        btn_raw[0] = 1'b0;
        step(6);
        atc_clr = 8'h01;
        step(1);
        atc_clr = '0;
        chk("set_wins", atc_flag, 8'h01);

        // Simultaneous release of 0 and 7, switch sampling
        atc_clr = 8'h01;
        step(1);
        atc_clr = '0;
        sw_raw  = 8'h3C;
        btn_raw = 8'h81;
        step(8);
        btn_raw = 8'h00;
        step(7);
        chk("two_rel", atc_flag, 8'h81);
        atc_clr = 8'h80;
        step(1);
        atc_clr = '0;
        chk("clr7", atc_flag, 8'h01);
        sw_raw = 8'hFF;
        step(2);
        chk("dinp_lat2", dinp, 8'h3C);
        step(1);
`ifdef RPN_DINP_CAPTURE_EN
        chk("dinp_held", dinp, 8'h3C);
`else
        chk("dinp_lat3", dinp, 8'hFF);
`endif

        // Asynchronous reset mid-count with flags pending
        btn_raw = 8'h04;
        step(8);
        btn_raw = 8'h00;
        step(7);
        chk("flags05", atc_flag, 8'h05);
        btn_raw = 8'h08;
        step(3);
        #2 reset = 1'b0;
        #1;
        chk("arst_flag", atc_flag, 8'h00);
        chk("arst_level", btn_level, 8'h00);
        chk("arst_dinp", dinp, 8'h00);
        step(2);
        reset = 1'b1;
        step(5);
        chk("rearm_lvl_early", btn_level, 8'h00);
        step(1);
        chk("rearm_lvl", btn_level, 8'h08);
        chk("rearm_flag", atc_flag, 8'h00);
        btn_raw = 8'h00;
        step(7);
        chk("rearm_rel", atc_flag, 8'h08);

        // Randomized buttons, switches and consume strobes
        for (int i = 0; i < NB; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NB; i++) begin
                if (hold[i] == 0) begin
                    btn_raw[i] = 1'($urandom_range(0, 1));
                    hold[i]    = $urandom_range(1, 9);
                end else begin
                    hold[i]--;
                end
            end
            if ($urandom_range(0, 15) == 0) sw_raw = 8'($urandom);
            atc_clr = 8'($urandom & $urandom & $urandom);
            step(1);
        end
        atc_clr = '0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
